// File: rtl/pes_fdiv_pkg.sv
// Shared types and constants for the pes_fdiv shift-subtract divider.
package pes_fdiv_pkg;

    localparam int N_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHK   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/pes_fdiv_step.sv
// One restoring-division iteration: shift {R,Q} left, then conditionally subtract DIV from R.
module pes_fdiv_step
    import pes_fdiv_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [2*N:0] acc,
    input  logic [N-1:0] div,
    output logic [2*N:0] acc_next
);

    logic [2*N:0] acc_sh;
    logic [N:0]   upper;

    always_comb begin
        acc_sh   = acc << 1;
        upper    = acc_sh[2*N:N];
        acc_next = acc_sh;
        // R keeps N+1 bits so the bit shifted out of the old MSB takes part in the compare.
        if (upper >= {1'b0, div}) begin
            acc_next[2*N:N] = upper - {1'b0, div};
            acc_next[0]     = 1'b1;
        end
    end

endmodule

// File: rtl/pes_fdiv.sv
// Sequential unsigned divider: 2N-bit dividend / N-bit divisor, St/Done handshake shared with pes_fmul.
// Handshake: St is accepted only in IDLE; Done pulses one cycle with Quotient/Remainder/Ovf valid and held.
module pes_fdiv
    import pes_fdiv_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           St,
    input  logic [2*N-1:0] Dividend,
    input  logic [N-1:0]   Divisor,
    output logic [N-1:0]   Quotient,
    output logic [N-1:0]   Remainder,
    output logic           Done,
    output logic           Ovf,
    output logic [1:0]     dbg_state
);

    localparam int CW = $clog2(N) + 1;

    state_e         state_q, state_d;
    logic [2*N:0]   acc_q, acc_d;
    logic [N-1:0]   div_q, div_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           done_q, done_d;
    logic           ovf_q, ovf_d;
    logic [2*N:0]   acc_step;

    pes_fdiv_step #(.N(N)) u_step (
        .acc      (acc_q),
        .div      (div_q),
        .acc_next (acc_step)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (St) begin
                    acc_d   = {1'b0, Dividend};
                    div_d   = Divisor;
                    state_d = CHK;
                end
            end
            CHK: begin
                // Quotient fits in N bits only if the upper dividend half is below DIV; also traps DIV=0.
                if (acc_q[2*N-1:N] >= div_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    ovf_d   = 1'b1;
                    quo_d   = '0;
                    rem_d   = '0;
                end else begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    ovf_d   = 1'b0;
                    quo_d   = acc_step[N-1:0];
                    rem_d   = acc_step[2*N-1:N];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            acc_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Quotient  = quo_q;
    assign Remainder = rem_q;
    assign Done      = done_q;
    assign Ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pes_fdiv.sv
// Directed bench for pes_fdiv: an N=4 instance for most vectors, an N=8 instance for 200/3.
module tb_pes_fdiv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        st;
    logic [7:0]  dvd;
    logic [3:0]  dvs;
    logic [3:0]  quo, rem;
    logic        done, ovf;
    logic [1:0]  dbg;

    logic        st8;
    logic [15:0] dvd8;
    logic [7:0]  dvs8;
    logic [7:0]  quo8, rem8;
    logic        done8, ovf8;
    logic [1:0]  dbg8;

    int n_checks = 0;
    int n_errors = 0;

    pes_fdiv #(.N(4)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .St        (st),
        .Dividend  (dvd),
        .Divisor   (dvs),
        .Quotient  (quo),
        .Remainder (rem),
        .Done      (done),
        .Ovf       (ovf),
        .dbg_state (dbg)
    );

    pes_fdiv #(.N(8)) dut8 (
        .CLK       (clk),
        .RST_N     (rst_n),
        .St        (st8),
        .Dividend  (dvd8),
        .Divisor   (dvs8),
        .Quotient  (quo8),
        .Remainder (rem8),
        .Done      (done8),
        .Ovf       (ovf8),
        .dbg_state (dbg8)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // All driving and sampling happens 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [3:0] b,
                          input logic [3:0] eq, input logic [3:0] er, input logic eo,
                          input int elat);
        int e;
        e   = 0;
        st  = 1'b1;
        dvd = a;
        dvs = b;
        tick();
        st  = 1'b0;
        dvd = 8'($urandom);
        dvs = 4'($urandom);
        while (!done && e < 20) begin
            tick();
            e++;
        end
        check({tag, "_done"}, 16'(done), 16'd1);
        check({tag, "_lat"}, 16'(e + 1), 16'(elat));
        check({tag, "_q"}, 16'(quo), 16'(eq));
        check({tag, "_r"}, 16'(rem), 16'(er));
        check({tag, "_ovf"}, 16'(ovf), 16'(eo));
        tick();
        check({tag, "_pulse"}, 16'(done), 16'd0);
        check({tag, "_idle"}, 16'(dbg), 16'd0);
    endtask

    initial begin
        int e;
        int pulses;
        int prev;

        rst_n = 1'b0;
        st    = 1'b0;
        dvd   = '0;
        dvs   = '0;
        st8   = 1'b0;
        dvd8  = '0;
        dvs8  = '0;
        repeat (2) tick();
        check("rst_q", 16'(quo), 16'd0);
        check("rst_r", 16'(rem), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_ovf", 16'(ovf), 16'd0);
        check("rst_state", 16'(dbg), 16'd0);
        rst_n = 1'b1;
        tick();

        run_op("d100_7", 8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 6);
        run_op("d135_13", 8'd135, 4'd13, 4'd10, 4'd5, 1'b0, 6);
        run_op("d0_5", 8'd0, 4'd5, 4'd0, 4'd0, 1'b0, 6);
        run_op("d255_15", 8'd255, 4'd15, 4'd0, 4'd0, 1'b1, 2);
        run_op("d37_0", 8'd37, 4'd0, 4'd0, 4'd0, 1'b1, 2);
        run_op("d100_7b", 8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 6);

        // 200/3 on the 8-bit divider, with a start re-pulse and changed operands mid-SHIFT.
        st8  = 1'b1;
        dvd8 = 16'd200;
        dvs8 = 8'd3;
        tick();
        st8 = 1'b0;
        tick();
        tick();
        st8  = 1'b1;
        dvd8 = 16'd9;
        dvs8 = 8'd9;
        tick();
        st8    = 1'b0;
        pulses = 0;
        prev   = -1;
        for (int k = 4; k < 26; k++) begin
            tick();
            if (done8) begin
                pulses++;
                prev = k;
                check("d200_3_q", 16'(quo8), 16'd66);
                check("d200_3_r", 16'(rem8), 16'd2);
                check("d200_3_ovf", 16'(ovf8), 16'd0);
            end
        end
        check("d200_3_pulses", 16'(pulses), 16'd1);
        check("d200_3_lat", 16'(prev + 1), 16'd10);

        // Reset at iteration 2 of 150/11 aborts the op and clears held results.
        st  = 1'b1;
        dvd = 8'd150;
        dvs = 4'd11;
        tick();
        st = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("abort_q", 16'(quo), 16'd0);
        check("abort_r", 16'(rem), 16'd0);
        check("abort_ovf", 16'(ovf), 16'd0);
        check("abort_done", 16'(done), 16'd0);
        check("abort_state", 16'(dbg), 16'd0);
        rst_n  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) pulses++;
        end
        check("abort_no_done", 16'(pulses), 16'd0);
        run_op("d150_11", 8'd150, 4'd11, 4'd13, 4'd7, 1'b0, 6);

        // St held high: a new op every 7 cycles.
        st     = 1'b1;
        dvd    = 8'd64;
        dvs    = 4'd8;
        pulses = 0;
        prev   = -1;
        for (e = 0; e < 22; e++) begin
            tick();
            if (done) begin
                pulses++;
                check("held_q", 16'(quo), 16'd8);
                check("held_r", 16'(rem), 16'd0);
                if (prev >= 0) check("held_gap", 16'(e - prev), 16'd7);
                else check("held_first", 16'(e), 16'd5);
                prev = e;
            end
        end
        check("held_pulses", 16'(pulses), 16'd3);
        st = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pes_fdiv.md
# pes_fdiv

Sequential shift-subtract divider, the inverse of the `pes_fmul` shift-add multiplier. A start pulse loads a 2N-bit dividend and an N-bit divisor. The block then produces an N-bit quotient and an N-bit remainder after a fixed number of cycles, signalled by a one-cycle `Done` pulse. Overflow (quotient does not fit in N bits, or divisor zero) is detected up front and reported without iterating. The block shares the same start/done handshake as `pes_fmul`, so one controller can drive both.

## Interface
- `N`, default 4: divisor, quotient and remainder width; the dividend is 2N bits.
- `CLK` in 1: single clock, rising-edge active.
- `RST_N` in 1: synchronous, active-low reset.
- `St` in 1: start request, sampled only in IDLE.
- `Dividend` in 2N: dividend, sampled on the accepting edge.
- `Divisor` in N: divisor, sampled on the accepting edge.
- `Quotient` out N: registered result.
- `Remainder` out N: registered result.
- `Done` out 1: one-cycle pulse, results valid.
- `Ovf` out 1: registered; qualifies the results presented with `Done`.

## Operation
- Internal registers:
  - ACC: 2N+1 bits, {R[N:0], Q[N-1:0]}.
  - DIV: N bits.
  - CNT: ceil(log2 N)+1 bits.
  - state.
- States and transitions:
  - IDLE: if `St`=1, load ACC = {1'b0, Dividend} and DIV = `Divisor`, then go to CHK.
  - CHK: overflow = (Dividend[2N-1:N] >= DIV). This covers DIV=0. On overflow go to DONE with `Ovf`=1. Otherwise CNT=0 and go to SHIFT.
  - SHIFT: ACC <= ACC << 1.
    - If ACC_shifted[2N:N] >= {1'b0, DIV}, subtract DIV from the upper N+1 bits and set ACC[0]=1.
    - Shift, compare and subtract happen in the same cycle.
    - CNT++. After the Nth iteration go to DONE.
  - DONE: `Done`=1 for exactly one cycle, then go to IDLE unconditionally.
- Result update:
  - On entry to DONE, without overflow: `Quotient`=ACC[N-1:0], `Remainder`=ACC[2N-1:N], `Ovf`=0.
  - On overflow: `Quotient`=0, `Remainder`=0, `Ovf`=1.
  - Outputs hold until the next entry to DONE.
- Arithmetic rules:
  - Unsigned only.
  - R is N+1 bits so the bit shifted out of the MSB is never lost.
  - The compare is N+1 bits against a zero-extended DIV.
- Handshake rules:
  - `St` is ignored in CHK, SHIFT and DONE; there is no queueing.
  - `Dividend` and `Divisor` may change freely after the accepting edge.
  - If `St` is held high, a new operation starts from the IDLE cycle following DONE.

## Timing
- Reset: while `RST_N`=0 at an edge, state=IDLE and ACC, DIV, CNT, `Quotient`, `Remainder`, `Done`, `Ovf` are all 0. Reset applies in any state and aborts an operation in progress; no `Done` is produced for the aborted operation.
- Latency, with the accepting edge as edge 0:
  - Normal: `Done` is high in the cycle after edge N+1 (N+2 edges; 6 for N=4).
  - Overflow: `Done` is high after edge 1 (2 edges).
- Throughput: one operation per N+3 cycles (normal) or 3 cycles (overflow), counting the mandatory IDLE cycle.
- `Done` is registered and never high in two consecutive cycles.

## Structure
- Package `pes_fdiv_pkg` holds:
  - state encoding constants IDLE=0, CHK=1, SHIFT=2, DONE=3;
  - default width constant N=4.
- One natural sub-module, `pes_fdiv_step`: purely combinational. It takes ACC (2N+1) and DIV (N) and returns the next ACC for one shift-compare-subtract iteration. The top level holds the FSM, counter and output registers.

## Test plan
- 100 / 7, `St` one cycle: `Done` 6 edges later, `Quotient`=14, `Remainder`=2, `Ovf`=0.
- 135 / 13: `Quotient`=10, `Remainder`=5, `Ovf`=0. Follow back-to-back with 0 / 5: `Quotient`=0, `Remainder`=0.
- 255 / 15, then 37 / 0: each gives `Done` 2 edges after start, `Ovf`=1, `Quotient`=0, `Remainder`=0.
- 200 / 3 with `St` re-pulsed during SHIFT and inputs changed to 9 / 9: the re-pulse is ignored, the result is `Quotient`=66, `Remainder`=2, and only one `Done` pulse occurs.
- `RST_N` low for one edge at iteration 2 of 150 / 11:
  - all outputs are 0 and no `Done` follows;
  - a fresh 150 / 11 then gives `Quotient`=13, `Remainder`=7.
- `St` held high continuously with 64 / 8: repeated `Done` pulses every 7 cycles, each with `Quotient`=8, `Remainder`=0.
